// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage MIPS datapath.
//   Produces fetch/decode stalls and the ID/EX flush for load-use, branch
//   and HI/LO (multiply/divide unit) hazards. It also produces forwarding
//   selects for the EX ALU operands and for the D-stage branch comparator,
//   and tracks how long the multi-cycle MDU stays busy.
// Ports:
//   clk, rst (async, active-low)
//   rsD/rtD, rsE/rtE                   source registers in D and E
//   writeregE/M/W, regwriteE/M/W       destination register and write enable per stage
//   memtoregE/M                        stage holds a load
//   branchD, mduseD, mdstartE          branch in D, HI/LO use in D, MDU start in E
//   stallF, stallD, flushE             combinational stall / bubble controls
//   forwardAD/BD                       branch operand from the M-stage ALU result
//   forwardAE/BE                       00 register file, 01 W result, 10 M ALU result
//   mdbusy                             MDU busy (derived from the counter register)
module hazard_unit #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned MD_CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       mduseD,
  input  logic       mdstartE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       mdbusy
);

  localparam logic [MD_CNT_W-1:0] LATENCY = MD_CNT_W'(MD_LATENCY);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  logic hit_m_rse, hit_w_rse, hit_m_rte, hit_w_rte;
  logic hit_e_d, hit_m_d;
  logic lwstall, branchstall, mdstall, stall;

  // Destination register 0 is hard-wired to zero, so it never matches.
  always_comb begin
    hit_m_rse = regwriteM && (writeregM != '0) && (writeregM == rsE);
    hit_w_rse = regwriteW && (writeregW != '0) && (writeregW == rsE);
    hit_m_rte = regwriteM && (writeregM != '0) && (writeregM == rtE);
    hit_w_rte = regwriteW && (writeregW != '0) && (writeregW == rtE);
    hit_e_d   = (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
    hit_m_d   = (writeregM != '0) && ((writeregM == rsD) || (writeregM == rtD));
  end

  always_comb begin
    // The M stage holds the newer value, so it wins over W.
    forwardAE = hit_m_rse ? 2'b10 : (hit_w_rse ? 2'b01 : 2'b00);
    forwardBE = hit_m_rte ? 2'b10 : (hit_w_rte ? 2'b01 : 2'b00);
    forwardAD = regwriteM && (writeregM != '0) && (writeregM == rsD);
    forwardBD = regwriteM && (writeregM != '0) && (writeregM == rtD);
  end

  always_comb begin
    lwstall     = memtoregE && regwriteE && hit_e_d;
    // A D-stage branch needs its operands now. A result still in E is not
    // ready yet, and neither is load data still in M.
    branchstall = branchD && ((regwriteE && hit_e_d) || (memtoregM && hit_m_d));
    mdstall     = mduseD && mdbusy;
    stall       = lwstall || branchstall || mdstall;
    stallF      = stall;
    stallD      = stall;
    flushE      = stall;
  end

  // A new start always reloads the counter, even while the MDU is busy.
  // Otherwise the counter counts down to zero and stays there.
  always_comb begin
    cnt_d = cnt_q;
    if (mdstartE) begin
      cnt_d = LATENCY;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mdbusy = (cnt_q != '0);

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit, built with MD_LATENCY = 4.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, mduseD, mdstartE;
  logic       stallF, stallD, flushE, forwardAD, forwardBD, mdbusy;
  logic [1:0] forwardAE, forwardBE;

  int checks   = 0;
  int failures = 0;

  // One stimulus row with the outputs expected for it.
  typedef struct {
    int rsd, rtd, rse, rte, we, wm, ww;
    int rwe, rwm, rww, mte, mtm, brd, mdu, mds;
    int xs, xfae, xfbe, xfad, xfbd, xbusy;
  } row_t;

  typedef struct {
    string      name;
    int         idx;
    logic [9:0] v;
  } sb_t;

  sb_t exp_q[$];

  hazard_unit #(.MD_LATENCY(4), .MD_CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .mduseD(mduseD), .mdstartE(mdstartE),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mdbusy(mdbusy)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {stallF, stallD, flushE, forwardAE, forwardBE, forwardAD, forwardBD, mdbusy};
  endfunction

  function automatic logic [9:0] expv(input row_t r);
    return {r.xs[0], r.xs[0], r.xs[0], r.xfae[1:0], r.xfbe[1:0],
            r.xfad[0], r.xfbd[0], r.xbusy[0]};
  endfunction

  task automatic drive(input row_t r);
    rsD = 5'(r.rsd); rtD = 5'(r.rtd); rsE = 5'(r.rse); rtE = 5'(r.rte);
    writeregE = 5'(r.we); writeregM = 5'(r.wm); writeregW = 5'(r.ww);
    regwriteE = r.rwe[0]; regwriteM = r.rwm[0]; regwriteW = r.rww[0];
    memtoregE = r.mte[0]; memtoregM = r.mtm[0];
    branchD = r.brd[0]; mduseD = r.mdu[0]; mdstartE = r.mds[0];
  endtask

  // Column order for the tables below:
  // rsD rtD rsE rtE | wE wM wW | rwE rwM rwW | mtE mtM | brD mdu mds | stall fAE fBE fAD fBD busy

  task automatic test_reset();
    row_t z = '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0};
    sb_t  e;
    rst = 1'b0;
    drive(z);
    exp_q.push_back('{"reset", 0, 10'b0});
    #3;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    row_t rows [4] = '{
      '{8,0,0,0, 8,0,0, 1,0,0, 1,0, 0,0,0, 1,0,0,0,0,0},
      '{0,0,8,0, 0,8,0, 0,1,0, 0,1, 0,0,0, 0,2,0,0,0,0},
      '{0,8,0,0, 8,0,0, 1,0,0, 1,0, 0,0,0, 1,0,0,0,0,0},
      '{8,0,0,0, 8,0,0, 1,0,0, 0,0, 0,0,0, 0,0,0,0,0,0}
    };
    sb_t e;
    foreach (rows[i]) begin
      @(posedge clk); #1;
      drive(rows[i]);
      exp_q.push_back('{"load_use", i, expv(rows[i])});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
      end
    end
  endtask

  task automatic test_forward();
    row_t rows [6] = '{
      '{0,0,0,5, 0,5,5, 0,1,1, 0,0, 0,0,0, 0,0,2,0,0,0},
      '{0,0,0,5, 0,5,5, 0,0,1, 0,0, 0,0,0, 0,0,1,0,0,0},
      '{0,0,0,0, 0,0,0, 0,1,1, 0,0, 0,0,0, 0,0,0,0,0,0},
      '{0,0,7,0, 0,0,7, 0,0,1, 0,0, 0,0,0, 0,1,0,0,0,0},
      '{0,0,7,7, 0,7,7, 0,1,1, 0,0, 0,0,0, 0,2,2,0,0,0},
      '{5,5,0,0, 0,5,0, 0,1,0, 0,0, 0,0,0, 0,0,0,1,1,0}
    };
    sb_t e;
    foreach (rows[i]) begin
      @(posedge clk); #1;
      drive(rows[i]);
      exp_q.push_back('{"forward", i, expv(rows[i])});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
      end
    end
  endtask

  task automatic test_branch();
    row_t rows [6] = '{
      '{3,0,0,0, 3,0,0, 1,0,0, 0,0, 1,0,0, 1,0,0,0,0,0},
      '{3,0,0,0, 0,3,0, 0,1,0, 0,0, 1,0,0, 0,0,0,1,0,0},
      '{3,0,0,0, 0,3,0, 0,1,0, 0,1, 1,0,0, 1,0,0,1,0,0},
      '{0,3,0,0, 3,0,0, 1,0,0, 0,0, 1,0,0, 1,0,0,0,0,0},
      '{3,0,0,0, 3,0,0, 1,0,0, 0,0, 0,0,0, 0,0,0,0,0,0},
      '{3,0,0,0, 3,0,0, 0,0,0, 0,0, 1,0,0, 0,0,0,0,0,0}
    };
    sb_t e;
    foreach (rows[i]) begin
      @(posedge clk); #1;
      drive(rows[i]);
      exp_q.push_back('{"branch", i, expv(rows[i])});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
      end
    end
  endtask

  task automatic test_reg_zero();
    row_t rows [2] = '{
      '{0,0,0,0, 0,0,0, 1,0,0, 1,0, 0,0,0, 0,0,0,0,0,0},
      '{0,0,0,0, 0,0,0, 1,1,1, 1,1, 1,0,0, 0,0,0,0,0,0}
    };
    sb_t e;
    foreach (rows[i]) begin
      @(posedge clk); #1;
      drive(rows[i]);
      exp_q.push_back('{"reg_zero", i, expv(rows[i])});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
      end
    end
  endtask

  // A single start pulse keeps the MDU busy for exactly four cycles. A HI/LO
  // user in D stalls during those cycles and is released on the first idle one.
  task automatic test_mdu();
    row_t rows [6] = '{
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,1,1, 0,0,0,0,0,0},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,1,0, 1,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,1,0, 1,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,1,0, 1,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,1,0, 1,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,1,0, 0,0,0,0,0,0}
    };
    sb_t e;
    foreach (rows[i]) begin
      @(posedge clk); #1;
      drive(rows[i]);
      exp_q.push_back('{"mdu", i, expv(rows[i])});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
      end
    end
  endtask

  // A second start two cycles after the first restarts the full latency.
  task automatic test_mdu_reload();
    row_t rows [8] = '{
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,1, 0,0,0,0,0,0},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,1, 0,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,1},
      '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0}
    };
    sb_t e;
    foreach (rows[i]) begin
      @(posedge clk); #1;
      drive(rows[i]);
      exp_q.push_back('{"mdu_reload", i, expv(rows[i])});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
      end
    end
  endtask

  // Reset is asserted between clock edges while the MDU is busy.
  task automatic test_mdu_async_reset();
    row_t start = '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,1, 0,0,0,0,0,0};
    row_t idle  = '{0,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0};
    sb_t  e;
    @(posedge clk); #1;
    drive(start);
    @(posedge clk); #1;
    drive(idle);
    @(posedge clk); #1;
    exp_q.push_back('{"mdu_rst_busy", 0, 10'b0000000001});
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
    end
    rst = 1'b0;
    exp_q.push_back('{"mdu_rst_drop", 0, 10'b0});
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e.v) begin
      failures++;
      $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp_q.push_back('{"mdu_rst_after", i, 10'b0});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got=%b exp=%b", e.name, e.idx, obs(), e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_reg_zero();
    test_mdu();
    test_mdu_reload();
    test_mdu_async_reset();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
